// File: rtl/add_tree_and_round_pkg.sv
// rtl/add_tree_and_round_pkg.sv - shared rounding-mode codes and width helper
package add_tree_and_round_pkg;

    localparam logic [1:0] RND_FLOOR   = 2'd0;
    localparam logic [1:0] RND_ZERO    = 2'd1;
    localparam logic [1:0] RND_HALF_UP = 2'd2;
    localparam logic [1:0] RND_EVEN    = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/add_tree_and_round_round_and_clip.sv
// rtl/add_tree_and_round_round_and_clip.sv - combinational scale by 2^-SHIFT, round, clip to OUT_W
module round_and_clip
    import add_tree_and_round_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int SHIFT = 2,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  sum_i,
    input  logic        [1:0]       mode_i,
    output logic signed [OUT_W-1:0] result_o,
    output logic                    clipped_o
);
    // One spare bit above the quotient so the rounding increment never wraps.
    localparam int RW = IN_W - SHIFT + 1;

    logic signed [RW-1:0] r;

    generate
        if (SHIFT == 0) begin : g_pass
            logic [1:0] unused_mode;
            assign unused_mode = mode_i;
            assign r = {sum_i[IN_W-1], sum_i};
        end else begin : g_round
            localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
            logic signed [RW-1:0] q;
            logic [SHIFT-1:0]     f;
            logic                 inc;

            assign q = {sum_i[IN_W-1], sum_i[IN_W-1:SHIFT]};
            assign f = sum_i[SHIFT-1:0];

            always_comb begin
                inc = 1'b0;
                case (mode_i)
                    RND_FLOOR:   inc = 1'b0;
                    RND_ZERO:    inc = sum_i[IN_W-1] & (|f);
                    RND_HALF_UP: inc = (f >= HALF);
                    default:     inc = (f > HALF) | ((f == HALF) & q[0]);
                endcase
            end

            assign r = q + {{(RW-1){1'b0}}, inc};
        end

        if (RW > OUT_W) begin : g_clip
            // Fits only when every bit from OUT_W-1 upward equals the sign.
            logic [RW-OUT_W:0] top;
            assign top       = r[RW-1:OUT_W-1];
            assign clipped_o = ~((&top) | ~(|top));
            assign result_o  = clipped_o ? (r[RW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                    : {1'b0, {(OUT_W-1){1'b1}}})
                                         : r[OUT_W-1:0];
        end else begin : g_fit
            assign clipped_o = 1'b0;
            assign result_o  = OUT_W'(r);
        end
    endgenerate

endmodule

// File: rtl/add_tree_and_round.sv
// rtl/add_tree_and_round.sv - pipelined N-input signed adder tree with rounding, clipping and sticky overflow
module add_tree_and_round
    import add_tree_and_round_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_IN    = 4,
    parameter int SHIFT     = 2,
    parameter int OUT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] i_tdata,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    input  logic [1:0]              round_mode,
    output logic [OUT_WIDTH-1:0]    o_tdata,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic                    overflow,
    input  logic                    clear_ovf
);
    localparam int LEVELS = clog2(NUM_IN);
    localparam int SW     = WIDTH + LEVELS;

    logic                        en;
    logic signed [SW-1:0]        stage_in [LEVELS][NUM_IN];
    logic signed [SW-1:0]        sum_d    [LEVELS][NUM_IN];
    logic signed [SW-1:0]        sum_q    [LEVELS][NUM_IN];
    logic [LEVELS-1:0]           vld_q;
    logic [LEVELS-1:0]           last_q;
    logic [1:0]                  mode_q   [LEVELS];
    logic signed [OUT_WIDTH-1:0] rc_result;
    logic                        rc_clipped;
    logic                        o_tvalid_q;
    logic                        o_tlast_q;
    logic [OUT_WIDTH-1:0]        o_tdata_q;
    logic                        overflow_q;
    logic                        overflow_d;

    assign en       = o_tready | ~o_tvalid_q;
    assign i_tready = en;

    always_comb begin
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                stage_in[l][i] = '0;
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            stage_in[0][i] = SW'($signed(i_tdata[i*WIDTH +: WIDTH]));
        end
        for (int l = 1; l < LEVELS; l++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                stage_in[l][i] = sum_q[l-1][i];
            end
        end
    end

    // Slots past a level's live count hold zero, so an unpaired operand
    // added to its zero neighbour passes through unchanged.
    always_comb begin
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                sum_d[l][i] = '0;
            end
            for (int i = 0; i < NUM_IN / 2; i++) begin
                sum_d[l][i] = stage_in[l][2*i] + stage_in[l][2*i+1];
            end
            if (NUM_IN % 2 == 1) begin
                sum_d[l][NUM_IN/2] = stage_in[l][NUM_IN-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < LEVELS; l++) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    sum_q[l][i] <= '0;
                end
                mode_q[l] <= RND_FLOOR;
            end
            vld_q      <= '0;
            last_q     <= '0;
            o_tvalid_q <= 1'b0;
            o_tlast_q  <= 1'b0;
            o_tdata_q  <= '0;
        end else if (en) begin
            sum_q     <= sum_d;
            vld_q[0]  <= i_tvalid;
            last_q[0] <= i_tlast;
            mode_q[0] <= round_mode;
            for (int l = 1; l < LEVELS; l++) begin
                vld_q[l]  <= vld_q[l-1];
                last_q[l] <= last_q[l-1];
                mode_q[l] <= mode_q[l-1];
            end
            o_tvalid_q <= vld_q[LEVELS-1];
            o_tlast_q  <= last_q[LEVELS-1];
            o_tdata_q  <= rc_result;
        end
    end

    round_and_clip #(
        .IN_W  (SW),
        .SHIFT (SHIFT),
        .OUT_W (OUT_WIDTH)
    ) u_round_and_clip (
        .sum_i     (sum_q[LEVELS-1][0]),
        .mode_i    (mode_q[LEVELS-1]),
        .result_o  (rc_result),
        .clipped_o (rc_clipped)
    );

    // A clipping beat landing in the output register beats a same-cycle clear.
    assign overflow_d = (en & vld_q[LEVELS-1] & rc_clipped) | (overflow_q & ~clear_ovf);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_tvalid = o_tvalid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_add_tree_and_round.sv
// tb/tb_add_tree_and_round.sv - directed and randomised checks of add_tree_and_round in four builds
module tb_add_tree_and_round;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        i_tlast, i_tvalid, o_tready, clear_ovf;
    logic [1:0]  round_mode;
    logic [63:0] tdata_a, tdata_z;
    logic [47:0] tdata_3;
    logic [79:0] tdata_5;
    logic        tready_a, tready_z, tready_3, tready_5;
    logic [15:0] odata_a, odata_z, odata_3, odata_5;
    logic        olast_a, olast_z, olast_3, olast_5;
    logic        ovalid_a, ovalid_z, ovalid_3, ovalid_5;
    logic        ovf_a, ovf_z, ovf_3, ovf_5;

    int checks   = 0;
    int failures = 0;
    logic [16:0] exp_q [$];

    add_tree_and_round #(.WIDTH(16), .NUM_IN(4), .SHIFT(2), .OUT_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_tdata(tdata_a), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(tready_a), .round_mode(round_mode), .o_tdata(odata_a), .o_tlast(olast_a),
        .o_tvalid(ovalid_a), .o_tready(o_tready), .overflow(ovf_a), .clear_ovf(clear_ovf));
    add_tree_and_round #(.WIDTH(16), .NUM_IN(4), .SHIFT(0), .OUT_WIDTH(16)) dut_z (
        .clk(clk), .reset_n(reset_n), .i_tdata(tdata_z), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(tready_z), .round_mode(round_mode), .o_tdata(odata_z), .o_tlast(olast_z),
        .o_tvalid(ovalid_z), .o_tready(o_tready), .overflow(ovf_z), .clear_ovf(clear_ovf));
    add_tree_and_round #(.WIDTH(16), .NUM_IN(3), .SHIFT(0), .OUT_WIDTH(16)) dut_3 (
        .clk(clk), .reset_n(reset_n), .i_tdata(tdata_3), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(tready_3), .round_mode(round_mode), .o_tdata(odata_3), .o_tlast(olast_3),
        .o_tvalid(ovalid_3), .o_tready(o_tready), .overflow(ovf_3), .clear_ovf(clear_ovf));
    add_tree_and_round #(.WIDTH(16), .NUM_IN(5), .SHIFT(0), .OUT_WIDTH(16)) dut_5 (
        .clk(clk), .reset_n(reset_n), .i_tdata(tdata_5), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(tready_5), .round_mode(round_mode), .o_tdata(odata_5), .o_tlast(olast_5),
        .o_tvalid(ovalid_5), .o_tready(o_tready), .overflow(ovf_5), .clear_ovf(clear_ovf));

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [15:0] model_out(input logic [63:0] td, input logic [1:0] m);
        longint s, q, f, r;
        s = 0;
        for (int k = 0; k < 4; k++) s += longint'($signed(td[k*16 +: 16]));
        q = s >>> 2;
        f = s - q * 4;
        case (m)
            2'd0:    r = q;
            2'd1:    r = q + ((s < 0 && f != 0) ? 1 : 0);
            2'd2:    r = q + ((f >= 2) ? 1 : 0);
            default: r = q + ((f > 2 || (f == 2 && q[0])) ? 1 : 0);
        endcase
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ovalid_a !== 1'b0) begin failures++; $display("FAIL reset_o_tvalid: got %b expected 0", ovalid_a); end
        checks++; if (odata_a !== 16'h0000) begin failures++; $display("FAIL reset_o_tdata: got %h expected 0000", odata_a); end
        checks++; if (olast_a !== 1'b0) begin failures++; $display("FAIL reset_o_tlast: got %b expected 0", olast_a); end
        checks++; if (ovf_a !== 1'b0 || ovf_z !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b%b expected 00", ovf_a, ovf_z); end
        checks++; if (tready_a !== 1'b1) begin failures++; $display("FAIL reset_i_tready: got %b expected 1", tready_a); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_latency_half_up();
        @(posedge clk); #1;
        round_mode = 2'd2; tdata_a = pack4(1, 1, 1, 1); i_tlast = 1'b0; i_tvalid = 1'b1;
        @(posedge clk); #1;
        tdata_a = pack4(1, 1, 1, 2); i_tlast = 1'b1;
        @(posedge clk); #1;
        i_tvalid = 1'b0; i_tlast = 1'b0;
        checks++; if (ovalid_a !== 1'b0) begin failures++; $display("FAIL lat_early: o_tvalid got %b expected 0", ovalid_a); end
        @(posedge clk); #1;
        checks++; if (ovalid_a !== 1'b1 || odata_a !== 16'd1 || olast_a !== 1'b0)
            begin failures++; $display("FAIL lat_beat0: got v=%b d=%h l=%b expected v=1 d=0001 l=0", ovalid_a, odata_a, olast_a); end
        @(posedge clk); #1;
        checks++; if (ovalid_a !== 1'b1 || odata_a !== 16'd1 || olast_a !== 1'b1)
            begin failures++; $display("FAIL lat_beat1: got v=%b d=%h l=%b expected v=1 d=0001 l=1", ovalid_a, odata_a, olast_a); end
        @(posedge clk); #1;
        checks++; if (ovalid_a !== 1'b0) begin failures++; $display("FAIL lat_drain: o_tvalid got %b expected 0", ovalid_a); end
    endtask

    task automatic test_round_modes();
        logic [15:0] exp_tab [8];
        exp_tab = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'd2, 16'd2, 16'd3, 16'd2};
        @(posedge clk); #1;
        for (int t = 0; t < 11; t++) begin
            if (t < 8) begin
                tdata_a    = (t < 4) ? pack4(-1, -1, -2, -2) : pack4(1, 2, 3, 4);
                round_mode = 2'(t % 4);
                i_tvalid   = 1'b1;
            end else begin
                i_tvalid = 1'b0;
            end
            if (t >= 3) begin
                checks++;
                if (ovalid_a !== 1'b1 || odata_a !== exp_tab[t-3]) begin
                    failures++;
                    $display("FAIL round_beat%0d: got v=%b d=%h expected v=1 d=%h", t - 3, ovalid_a, odata_a, exp_tab[t-3]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        @(posedge clk); #1;
        round_mode = 2'd2;
        tdata_a = pack4(32767, 32767, 32767, 32767); tdata_z = tdata_a; i_tvalid = 1'b1;
        @(posedge clk); #1; i_tvalid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (ovalid_z !== 1'b1 || odata_z !== 16'h7FFF) begin failures++; $display("FAIL sat_pos_data: got v=%b d=%h expected v=1 d=7fff", ovalid_z, odata_z); end
        checks++; if (ovf_z !== 1'b1) begin failures++; $display("FAIL sat_pos_ovf: got %b expected 1", ovf_z); end
        checks++; if (odata_a !== 16'h7FFF || ovf_a !== 1'b0) begin failures++; $display("FAIL sat_pos_noclip: got d=%h ovf=%b expected d=7fff ovf=0", odata_a, ovf_a); end
        @(posedge clk); #1;
        checks++; if (ovf_z !== 1'b1) begin failures++; $display("FAIL sat_sticky: got %b expected 1", ovf_z); end
        clear_ovf = 1'b1;
        @(posedge clk); #1; clear_ovf = 1'b0;
        checks++; if (ovf_z !== 1'b0) begin failures++; $display("FAIL sat_clear: got %b expected 0", ovf_z); end
        tdata_a = pack4(-32768, -32768, -32768, -32768); tdata_z = tdata_a; i_tvalid = 1'b1;
        @(posedge clk); #1; i_tvalid = 1'b0;
        @(posedge clk); #1; clear_ovf = 1'b1;
        @(posedge clk); #1; clear_ovf = 1'b0;
        checks++; if (ovalid_z !== 1'b1 || odata_z !== 16'h8000) begin failures++; $display("FAIL sat_neg_data: got v=%b d=%h expected v=1 d=8000", ovalid_z, odata_z); end
        checks++; if (ovf_z !== 1'b1) begin failures++; $display("FAIL sat_set_wins: got %b expected 1", ovf_z); end
        checks++; if (odata_a !== 16'h8000 || ovf_a !== 1'b0) begin failures++; $display("FAIL sat_neg_noclip: got d=%h ovf=%b expected d=8000 ovf=0", odata_a, ovf_a); end
        tdata_a = '0; tdata_z = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_odd_counts();
        @(posedge clk); #1;
        for (int t = 0; t < 7; t++) begin
            if (t == 0) begin
                tdata_3 = {16'sd7, -16'sd50, 16'sd100};
                tdata_5 = {16'sd3, 16'sd3, 16'sd7, -16'sd50, 16'sd100};
                i_tvalid = 1'b1;
            end else if (t == 1) begin
                tdata_3 = {-16'sd7, 16'sd50, -16'sd100};
                tdata_5 = {-16'sd3, -16'sd3, -16'sd7, 16'sd50, -16'sd100};
            end else begin
                i_tvalid = 1'b0;
            end
            if (t == 3) begin
                checks++; if (ovalid_3 !== 1'b1 || odata_3 !== 16'd57) begin failures++; $display("FAIL odd3_pos: got v=%b d=%h expected v=1 d=0039", ovalid_3, odata_3); end
            end
            if (t == 4) begin
                checks++; if (ovalid_3 !== 1'b1 || odata_3 !== 16'hFFC7) begin failures++; $display("FAIL odd3_neg: got v=%b d=%h expected v=1 d=ffc7", ovalid_3, odata_3); end
                checks++; if (ovalid_5 !== 1'b1 || odata_5 !== 16'd63) begin failures++; $display("FAIL odd5_pos: got v=%b d=%h expected v=1 d=003f", ovalid_5, odata_5); end
            end
            if (t == 5) begin
                checks++; if (ovalid_5 !== 1'b1 || odata_5 !== 16'hFFC1) begin failures++; $display("FAIL odd5_neg: got v=%b d=%h expected v=1 d=ffc1", ovalid_5, odata_5); end
            end
            @(posedge clk); #1;
        end
        tdata_3 = '0; tdata_5 = '0;
    endtask

    task automatic test_random_stream();
        int          sent, got;
        bit          stall_prev;
        logic [16:0] held, exp_beat;
        sent = 0; got = 0; stall_prev = 1'b0; held = '0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 3000 && (sent < 60 || exp_q.size() > 0); cyc++) begin
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (ovalid_a !== 1'b1 || {olast_a, odata_a} !== held) begin
                    failures++;
                    $display("FAIL rand_stall_hold: got v=%b %h expected v=1 %h", ovalid_a, {olast_a, odata_a}, held);
                end
            end
            if (i_tvalid && tready_a) begin
                exp_q.push_back({i_tlast, model_out(tdata_a, round_mode)});
                sent++;
            end
            if (ovalid_a && o_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra_beat: got %h expected no beat", {olast_a, odata_a});
                end else begin
                    exp_beat = exp_q.pop_front();
                    if ({olast_a, odata_a} !== exp_beat) begin
                        failures++;
                        $display("FAIL rand_beat%0d: got %h expected %h", got, {olast_a, odata_a}, exp_beat);
                    end
                end
                got++;
            end
            stall_prev = ovalid_a && !o_tready;
            held       = {olast_a, odata_a};
            @(posedge clk); #1;
            o_tready   = ($urandom_range(0, 1) == 1);
            i_tvalid   = (sent < 60) && ($urandom_range(0, 1) == 1);
            tdata_a    = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
            round_mode = 2'($urandom_range(0, 3));
            i_tlast    = ($urandom_range(0, 3) == 0);
        end
        checks++;
        if (sent != 60 || exp_q.size() != 0 || got != 60) begin
            failures++;
            $display("FAIL rand_drain: got sent=%0d out=%0d pending=%0d expected 60/60/0", sent, got, exp_q.size());
        end
        i_tvalid = 1'b0; o_tready = 1'b1; i_tlast = 1'b0; tdata_a = '0; round_mode = 2'd0;
        exp_q.delete();
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_midflight();
        int nvalid;
        @(posedge clk); #1;
        o_tready = 1'b1; round_mode = 2'd0;
        for (int t = 0; t < 3; t++) begin
            tdata_a  = pack4(100 * (t + 1), 100 * (t + 1), 100 * (t + 1), 100 * (t + 1));
            i_tvalid = 1'b1;
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0;
        checks++; if (ovalid_a !== 1'b1 || odata_a !== 16'd100) begin failures++; $display("FAIL midrst_pre: got v=%b d=%h expected v=1 d=0064", ovalid_a, odata_a); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ovalid_a !== 1'b0 || odata_a !== 16'h0000) begin failures++; $display("FAIL midrst_async: got v=%b d=%h expected v=0 d=0000", ovalid_a, odata_a); end
        @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        tdata_a = pack4(11, 11, 11, 11); i_tvalid = 1'b1;
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ovalid_a) begin
                nvalid++;
                checks++;
                if (odata_a !== 16'd11) begin failures++; $display("FAIL midrst_beat: got %h expected 000b", odata_a); end
            end
        end
        checks++; if (nvalid != 1) begin failures++; $display("FAIL midrst_count: got %0d beats expected 1", nvalid); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1; clear_ovf = 1'b0;
        round_mode = 2'd0; tdata_a = '0; tdata_z = '0; tdata_3 = '0; tdata_5 = '0;
        test_reset();
        test_latency_half_up();
        test_round_modes();
        test_saturation();
        test_odd_counts();
        test_random_stream();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
